// File: rtl/fcmp_pipe_if.sv
// Operand/result handshake bundle for fcmp_pipe.
// master = producer/consumer side, slave = the comparator.
interface fcmp_pipe_if #(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int TW = 4
);
  localparam int W = 1 + EW + MW;

  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  x1;
  logic [W-1:0]  x2;
  logic [1:0]    op;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic          v;
  logic          nv;
  logic [TW-1:0] out_tag;

  modport master (
    output in_valid, x1, x2, op, in_tag, out_ready,
    input  in_ready, out_valid, v, nv, out_tag
  );

  modport slave (
    input  in_valid, x1, x2, op, in_tag, out_ready,
    output in_ready, out_valid, v, nv, out_tag
  );
endinterface

// File: rtl/fcmp_pipe.sv
// Two-stage floating-point compare (FEQ/FLT/FLE) with valid/ready flow control.
// S1 holds operand classification and magnitude compare; S2 holds v/nv/tag.
module fcmp_pipe #(
  parameter int EW = 8,
  parameter int MW = 23,
  parameter int TW = 4
) (
  input logic        clk,
  input logic        rst,
  fcmp_pipe_if.slave bus
);
  localparam int W = 1 + EW + MW;
  localparam logic [1:0] OP_FEQ = 2'b00;
  localparam logic [1:0] OP_FLT = 2'b01;
  localparam logic [1:0] OP_FLE = 2'b10;

  logic [EW-1:0]  exp1, exp2;
  logic [MW-1:0]  man1, man2;
  logic [W-2:0]   mag1, mag2;
  logic           nan1, nan2, snan1, snan2, zero1, zero2;

  logic           s1_valid;
  logic [1:0]     s1_op;
  logic [TW-1:0]  s1_tag;
  logic           s1_sign1, s1_sign2;
  logic           s1_nan, s1_snan, s1_zeros;
  logic           s1_mag_lt, s1_mag_eq;

  logic           s1_ready, s2_ready;
  logic           lt, eq, v_d, nv_d;

  assign exp1 = bus.x1[W-2 -: EW];
  assign exp2 = bus.x2[W-2 -: EW];
  assign man1 = bus.x1[MW-1:0];
  assign man2 = bus.x2[MW-1:0];
  assign mag1 = bus.x1[W-2:0];
  assign mag2 = bus.x2[W-2:0];

  assign nan1  = (&exp1) && (|man1);
  assign nan2  = (&exp2) && (|man2);
  assign snan1 = nan1 && !man1[MW-1];
  assign snan2 = nan2 && !man2[MW-1];
  assign zero1 = ~|mag1;
  assign zero2 = ~|mag2;

  assign s2_ready     = !bus.out_valid || bus.out_ready;
  assign s1_ready     = !s1_valid || s2_ready;
  // held low during reset; depends only on state and out_ready, never on in_valid
  assign bus.in_ready = !rst && s1_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_op     <= '0;
      s1_tag    <= '0;
      s1_sign1  <= 1'b0;
      s1_sign2  <= 1'b0;
      s1_nan    <= 1'b0;
      s1_snan   <= 1'b0;
      s1_zeros  <= 1'b0;
      s1_mag_lt <= 1'b0;
      s1_mag_eq <= 1'b0;
    end else if (s1_ready) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_op     <= bus.op;
        s1_tag    <= bus.in_tag;
        s1_sign1  <= bus.x1[W-1];
        s1_sign2  <= bus.x2[W-1];
        s1_nan    <= nan1 || nan2;
        s1_snan   <= snan1 || snan2;
        s1_zeros  <= zero1 && zero2;
        s1_mag_lt <= mag1 < mag2;
        s1_mag_eq <= mag1 == mag2;
      end
    end
  end

  // Ordering: both zeros equal regardless of sign; mixed signs put negative
  // first; negative pairs reverse the magnitude order.
  always_comb begin
    lt = 1'b0;
    eq = 1'b0;
    if (s1_zeros) begin
      eq = 1'b1;
    end else if (s1_sign1 != s1_sign2) begin
      lt = s1_sign1;
    end else if (!s1_sign1) begin
      lt = s1_mag_lt;
      eq = s1_mag_eq;
    end else begin
      lt = !s1_mag_lt && !s1_mag_eq;
      eq = s1_mag_eq;
    end
  end

  always_comb begin
    v_d  = 1'b0;
    nv_d = 1'b0;
    case (s1_op)
      OP_FEQ: begin
        v_d  = eq && !s1_nan;
        nv_d = s1_snan;
      end
      OP_FLT: begin
        v_d  = lt && !s1_nan;
        nv_d = s1_nan;
      end
      OP_FLE: begin
        v_d  = (lt || eq) && !s1_nan;
        nv_d = s1_nan;
      end
      default: begin
        v_d  = 1'b0;
        nv_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.v         <= 1'b0;
      bus.nv        <= 1'b0;
      bus.out_tag   <= '0;
    end else if (s2_ready) begin
      bus.out_valid <= s1_valid;
      if (s1_valid) begin
        bus.v       <= v_d;
        bus.nv      <= nv_d;
        bus.out_tag <= s1_tag;
      end
    end
  end
endmodule

// File: tb/tb_fcmp_pipe.sv
// Self-checking bench for fcmp_pipe: directed vector table, stall/reset
// sequences and randomized traffic against an integer-key reference model.
module tb_fcmp_pipe;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fcmp_pipe_if #(.EW(8), .MW(23), .TW(4)) bus ();

  fcmp_pipe #(.EW(8), .MW(23), .TW(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [3:0] tag;
    logic       v;
    logic       nv;
  } exp_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [1:0]  op;
    logic        v;
    logic        nv;
  } vec_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic held_valid = 1'b0;
  logic [5:0] held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [1:0] ref_cmp(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    logic na, nb, sa, sb_;
    longint ka, kb;
    na  = (a[30:23] == 8'hFF) && (a[22:0] != 0);
    nb  = (b[30:23] == 8'hFF) && (b[22:0] != 0);
    sa  = na && !a[22];
    sb_ = nb && !b[22];
    if (op == 2'b11) return 2'b01;
    if (na || nb) return {1'b0, (op == 2'b00) ? (sa || sb_) : 1'b1};
    ka = a[31] ? -longint'(a[30:0]) : longint'(a[30:0]);
    kb = b[31] ? -longint'(b[30:0]) : longint'(b[30:0]);
    case (op)
      2'b00:   return {ka == kb, 1'b0};
      2'b01:   return {ka < kb, 1'b0};
      default: return {ka <= kb, 1'b0};
    endcase
  endfunction

  task automatic step(input logic vld, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [3:0] tag, input logic ordy,
                      input logic [1:0] exp_vn, output logic acc);
    exp_t e;
    @(negedge clk);
    bus.in_valid  = vld;
    bus.x1        = a;
    bus.x2        = b;
    bus.op        = op;
    bus.in_tag    = tag;
    bus.out_ready = ordy;
    #1;
    if (held_valid && bus.out_valid)
      chk("stall_stable", {26'd0, bus.v, bus.nv, bus.out_tag}, {26'd0, held});
    held_valid = bus.out_valid && !bus.out_ready;
    held       = {bus.v, bus.nv, bus.out_tag};
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        chk("unexpected_result", {27'd0, 1'b1, bus.out_tag}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("result", {26'd0, bus.v, bus.nv, bus.out_tag}, {26'd0, e.v, e.nv, e.tag});
      end
    end
    acc = vld && bus.in_ready;
    if (acc) begin
      e.tag = tag;
      e.v   = exp_vn[1];
      e.nv  = exp_vn[0];
      sb.push_back(e);
    end
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 2'b00, 4'd0, 1'b1, 2'b00, acc);
  endtask

  function automatic logic [31:0] rand_operand();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 7))
      0: return {r[31], 31'd0};
      1: return {r[31], 8'hFF, 23'd0};
      2: return {r[31], 8'hFF, 1'b1, r[21:0]};
      3: return {r[31], 8'hFF, 1'b0, r[21:1], 1'b1};
      4: return {r[31], 8'h00, r[22:0]};
      5: return {r[31], 8'h3F, 23'd0};
      default: return r;
    endcase
  endfunction

  vec_t tbl[15];
  logic acc;
  logic [31:0] ra, rb;
  logic [1:0]  rop;
  int got_idx;

  initial begin
    tbl[0]  = '{32'h3F800000, 32'h40000000, 2'b10, 1'b1, 1'b0};
    tbl[1]  = '{32'h40000000, 32'h3F800000, 2'b01, 1'b0, 1'b0};
    tbl[2]  = '{32'h00000000, 32'h80000000, 2'b00, 1'b1, 1'b0};
    tbl[3]  = '{32'h00000000, 32'h80000000, 2'b01, 1'b0, 1'b0};
    tbl[4]  = '{32'h00000000, 32'h80000000, 2'b10, 1'b1, 1'b0};
    tbl[5]  = '{32'hC0000000, 32'hBF800000, 2'b01, 1'b1, 1'b0};
    tbl[6]  = '{32'h00000001, 32'h00800000, 2'b01, 1'b1, 1'b0};
    tbl[7]  = '{32'h7FC00000, 32'h3F800000, 2'b10, 1'b0, 1'b1};
    tbl[8]  = '{32'h7FC00000, 32'h3F800000, 2'b00, 1'b0, 1'b0};
    tbl[9]  = '{32'h7F800001, 32'h3F800000, 2'b00, 1'b0, 1'b1};
    tbl[10] = '{32'h3F800000, 32'h3F800000, 2'b11, 1'b0, 1'b1};
    tbl[11] = '{32'h7F800000, 32'h7F7FFFFF, 2'b01, 1'b0, 1'b0};
    tbl[12] = '{32'h7F7FFFFF, 32'h7F800000, 2'b01, 1'b1, 1'b0};
    tbl[13] = '{32'h80000000, 32'h00000001, 2'b01, 1'b1, 1'b0};
    tbl[14] = '{32'h3F800000, 32'h3F800000, 2'b00, 1'b1, 1'b0};

    bus.in_valid = 1'b1; bus.x1 = '0; bus.x2 = '0; bus.op = '0;
    bus.in_tag = '0; bus.out_ready = 1'b0;

    // reset: outputs cleared and in_ready low, then in_ready high right after
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
      if (i > 0) begin
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_v_nv_tag", {26'd0, bus.v, bus.nv, bus.out_tag}, 32'd0);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    chk("post_rst_in_ready", {31'd0, bus.in_ready}, 32'd1);

    // latency: accept then out_valid exactly two cycles later
    step(1'b1, 32'h3F800000, 32'h40000000, 2'b10, 4'd3, 1'b1, 2'b10, acc);
    chk("lat_accept", {31'd0, acc}, 32'd1);
    step(1'b0, '0, '0, 2'b00, 4'd0, 1'b1, 2'b00, acc);
    chk("lat_cycle1", {31'd0, bus.out_valid}, 32'd0);
    step(1'b0, '0, '0, 2'b00, 4'd0, 1'b1, 2'b00, acc);
    chk("lat_cycle2", {31'd0, bus.out_valid}, 32'd1);
    idle(2);

    // directed table, back-to-back
    for (int i = 0; i < 15; i++) begin
      step(1'b1, tbl[i].a, tbl[i].b, tbl[i].op, 4'(i), 1'b1, {tbl[i].v, tbl[i].nv}, acc);
      chk("tbl_accept", {31'd0, acc}, 32'd1);
    end
    idle(4);

    // stall: out_ready low for 4 cycles, tags 1,2,3 offered back-to-back
    step(1'b1, 32'h3F800000, 32'h40000000, 2'b01, 4'd1, 1'b0, 2'b10, acc);
    chk("stall_acc1", {31'd0, acc}, 32'd1);
    step(1'b1, 32'h3F800000, 32'h40000000, 2'b00, 4'd2, 1'b0, 2'b00, acc);
    chk("stall_acc2", {31'd0, acc}, 32'd1);
    got_idx = -1;
    for (int k = 2; k < 12; k++) begin
      step(1'b1, 32'h3F800000, 32'h40000000, 2'b11, 4'd3, (k < 4) ? 1'b0 : 1'b1, 2'b01, acc);
      if (k == 2) chk("stall_in_ready_low", {31'd0, acc}, 32'd0);
      if (acc) begin
        got_idx = k;
        break;
      end
    end
    chk("stall_acc3_cycle", got_idx, 32'd4);
    idle(4);
    chk("stall_drain", sb.size(), 32'd0);

    // reset with two results in flight
    step(1'b1, 32'h40000000, 32'h3F800000, 2'b01, 4'd5, 1'b0, 2'b00, acc);
    step(1'b1, 32'h40000000, 32'h3F800000, 2'b10, 4'd6, 1'b0, 2'b00, acc);
    @(negedge clk);
    rst = 1'b1;
    bus.in_valid = 1'b0;
    #1;
    sb.delete();
    held_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", {31'd0, bus.out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, bus.in_ready}, 32'd1);
    idle(5);

    // randomized traffic with random backpressure
    for (int i = 0; i < 600; i++) begin
      ra  = rand_operand();
      rb  = ($urandom_range(0, 5) == 0) ? ra : rand_operand();
      if ($urandom_range(0, 7) == 0) rb = {~ra[31], ra[30:0]};
      rop = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      step($urandom_range(0, 9) < 7, ra, rb, rop, 4'($urandom), $urandom_range(0, 9) < 7,
           ref_cmp(ra, rb, rop), acc);
    end
    idle(6);
    chk("final_drain", sb.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
